// File: rtl/seq_pattern_ctrl.sv
// Programmable serial pattern sequencer: emits pattern MSB-first, one bit per prescaler tick.
// Optional SEQ_PAUSE_EN adds a pause input that freezes the prescaler while running.
module seq_pattern_ctrl #(
    parameter int unsigned         PAT_W   = 16,
    parameter int unsigned         LEN_W   = 5,
    parameter int unsigned         DIV_W   = 28,
    parameter logic [PAT_W-1:0]    PAT_RST = PAT_W'(16'h0016),
    parameter logic [LEN_W-1:0]    LEN_RST = LEN_W'(5),
    parameter logic [DIV_W-1:0]    DIV_RST = DIV_W'((1 << 25) - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_loop,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [DIV_W-1:0] cfg_div,
`ifdef SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             cfg_rej,
    output logic             busy,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             done,
    output logic             led
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc_q;
    logic [LEN_W-1:0] idx_q;
    logic             loop_q;
    logic             bit_q;
    logic             led_q;
    logic             cfg_rej_q;

    logic             frozen;
    logic             count_en;
    logic             tick;
    logic             last;
    logic             cfg_ok;
    logic [LEN_W-1:0] bit_sel;
    logic             next_bit;

`ifdef SEQ_PAUSE_EN
    assign frozen = pause;
`else
    assign frozen = 1'b0;
`endif

    assign count_en = (state_q == StRun) && !frozen;
    assign tick     = count_en && (presc_q == div_q);
    assign last     = (idx_q == len_q - LEN_W'(1));
    assign bit_sel  = len_q - LEN_W'(1) - idx_q;
    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    always_comb begin
        next_bit = 1'b0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            if (LEN_W'(i) == bit_sel) next_bit = pat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pat_q     <= PAT_RST;
            len_q     <= LEN_RST;
            div_q     <= DIV_RST;
            presc_q   <= '0;
            idx_q     <= '0;
            loop_q    <= 1'b0;
            bit_q     <= 1'b0;
            led_q     <= 1'b0;
            cfg_rej_q <= 1'b0;
        end else begin
            cfg_rej_q <= 1'b0;
            if (cfg_we) begin
                if (state_q == StIdle && cfg_ok) begin
                    pat_q <= cfg_pattern;
                    len_q <= cfg_len;
                    div_q <= cfg_div;
                end else begin
                    cfg_rej_q <= 1'b1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_q <= StArm;
                        loop_q  <= mode_loop;
                    end
                end
                StArm: begin
                    presc_q <= '0;
                    idx_q   <= '0;
                    state_q <= StRun;
                    if (stop) begin
                        state_q <= StIdle;
                        bit_q   <= 1'b0;
                        led_q   <= 1'b0;
                    end
                end
                StRun: begin
                    if (count_en) begin
                        if (tick) begin
                            presc_q <= '0;
                            bit_q   <= next_bit;
                            led_q   <= ~led_q;
                            if (last) begin
                                idx_q <= '0;
                                if (!loop_q) state_q <= StDone;
                            end else begin
                                idx_q <= idx_q + LEN_W'(1);
                            end
                        end else begin
                            presc_q <= presc_q + DIV_W'(1);
                        end
                    end
                    // Abort overrides even the final tick, so no done pulse follows.
                    if (stop) begin
                        state_q <= StIdle;
                        bit_q   <= 1'b0;
                        led_q   <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    led_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The new bit is presented in the tick cycle itself, alongside bit_valid.
    assign bit_out   = tick ? next_bit : bit_q;
    assign bit_valid = tick;
    assign busy      = (state_q == StArm) || (state_q == StRun);
    assign done      = (state_q == StDone);
    assign led       = led_q;
    assign cfg_rej   = cfg_rej_q;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Directed self-checking bench for seq_pattern_ctrl; the pause scenario runs only with SEQ_PAUSE_EN.
module tb_seq_pattern_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        mode_loop;
    logic        cfg_we;
    logic [15:0] cfg_pattern;
    logic [4:0]  cfg_len;
    logic [27:0] cfg_div;
`ifdef SEQ_PAUSE_EN
    logic        pause;
`endif
    logic        cfg_rej;
    logic        busy;
    logic        bit_out;
    logic        bit_valid;
    logic        done;
    logic        led;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_pattern_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode_loop   (mode_loop),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_div     (cfg_div),
`ifdef SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .cfg_rej     (cfg_rej),
        .busy        (busy),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .done        (done),
        .led         (led)
    );

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [15:0] p, input logic [4:0] l, input logic [27:0] d);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_div     = d;
        next_cycle();
        cfg_we      = 1'b0;
    endtask

    // Returns in cycle T+1, where T is the cycle start was driven.
    task automatic start_run(input logic loop);
        start     = 1'b1;
        mode_loop = loop;
        next_cycle();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        outs = {cfg_rej, busy, bit_out, bit_valid, done, led};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 6'b0);
        end
    endtask

    task automatic test_oneshot_default();
        logic [4:0] exp_bits = 5'b10110;
        next_cycle();
        do_cfg(16'h0016, 5'd5, 28'd0);
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b0) begin
            failures++;
            $display("FAIL cfg_accept: cfg_rej got %b expected 0", cfg_rej);
        end
        next_cycle();
        start_run(1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL arm_busy: busy=%b bit_valid=%b expected 1/0", busy, bit_valid);
        end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (bit_valid !== 1'b1 || bit_out !== exp_bits[4-k] || led !== k[0]) begin
                failures++;
                $display("FAIL oneshot_bit%0d: valid=%b bit=%b led=%b expected 1/%b/%b",
                         k, bit_valid, bit_out, led, exp_bits[4-k], k[0]);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bit_valid !== 1'b0 || bit_out !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_done: done=%b busy=%b valid=%b bit=%b expected 1/0/0/0",
                     done, busy, bit_valid, bit_out);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || led !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_idle: done=%b led=%b expected 0/0", done, led);
        end
    endtask

    task automatic test_loop();
        logic [15:0] pat = 16'hA5A5;
        logic        exp_v;
        logic        exp_b;
        int          n;
        int          errs = 0;
        do_cfg(16'hA5A5, 5'd16, 28'd3);
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b0) begin
            failures++;
            $display("FAIL cfg_len16: cfg_rej got %b expected 0", cfg_rej);
        end
        next_cycle();
        start_run(1'b1);
        // 33 ticks: two full passes plus the first bit of the third.
        for (int c = 1; c <= 133; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            exp_v = (c >= 5) && (((c - 5) % 4) == 0);
            n     = (c - 5) / 4;
            exp_b = exp_v ? pat[15 - (n % 16)] : 1'b0;
            checks++;
            if (bit_valid !== exp_v || (exp_v && bit_out !== exp_b) ||
                done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                errs++;
                if (errs < 5)
                    $display("FAIL loop_c%0d: valid=%b bit=%b done=%b busy=%b expected %b/%b/0/1",
                             c, bit_valid, bit_out, done, busy, exp_v, exp_b);
            end
        end
        next_cycle();
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL loop_stop: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_cfg_reject();
        logic exp_v;
        logic [3:0] exp_bits = 4'b1010;
        next_cycle();
        start_run(1'b1);
        do_cfg(16'hFFFF, 5'd4, 28'd0);
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b1) begin
            failures++;
            $display("FAIL rej_busy: cfg_rej got %b expected 1", cfg_rej);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b0) begin
            failures++;
            $display("FAIL rej_pulse_len: cfg_rej got %b expected 0", cfg_rej);
        end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        do_cfg(16'hFFFF, 5'd0, 28'd0);
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b1) begin
            failures++;
            $display("FAIL rej_len0: cfg_rej got %b expected 1", cfg_rej);
        end
        do_cfg(16'hFFFF, 5'd17, 28'd0);
        @(negedge clk);
        checks++;
        if (cfg_rej !== 1'b1) begin
            failures++;
            $display("FAIL rej_len17: cfg_rej got %b expected 1", cfg_rej);
        end
        next_cycle();
        start_run(1'b0);
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) next_cycle();
            @(negedge clk);
            exp_v = (c >= 5) && (((c - 5) % 4) == 0);
            checks++;
            if (bit_valid !== exp_v || (exp_v && bit_out !== exp_bits[3 - (c - 5) / 4])) begin
                failures++;
                $display("FAIL readback_c%0d: valid=%b bit=%b expected valid %b", c,
                         bit_valid, bit_out, exp_v);
            end
        end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        do_cfg(16'hA5A5, 5'd16, 28'd3);
        next_cycle();
        start_run(1'b0);
        for (int c = 2; c <= 14; c++) next_cycle();
        next_cycle();
        stop = 1'b1;
        @(negedge clk);
        checks++;
        if (led !== 1'b1 || bit_out !== 1'b1) begin
            failures++;
            $display("FAIL pre_stop: led=%b bit=%b expected 1/1", led, bit_out);
        end
        next_cycle();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bit_out !== 1'b0 || led !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL stop_abort: busy=%b bit=%b led=%b done=%b expected 0/0/0/0",
                     busy, bit_out, led, done);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL stop_nodone%0d: done got %b expected 0", c, done);
            end
        end
        // Stop coinciding with the final tick: bit still emitted, no done.
        do_cfg(16'h0001, 5'd2, 28'd0);
        next_cycle();
        start_run(1'b0);
        next_cycle();
        @(negedge clk);
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin
            failures++;
            $display("FAIL final_first: valid=%b bit=%b expected 1/0", bit_valid, bit_out);
        end
        next_cycle();
        stop = 1'b1;
        @(negedge clk);
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
            failures++;
            $display("FAIL final_stop_bit: valid=%b bit=%b expected 1/1", bit_valid, bit_out);
        end
        next_cycle();
        stop = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bit_out !== 1'b0) begin
            failures++;
            $display("FAIL final_stop_after: done=%b busy=%b bit=%b expected 0/0/0",
                     done, busy, bit_out);
        end
        stop  = 1'b1;
        start = 1'b1;
        next_cycle();
        stop  = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || bit_valid !== 1'b0) begin
                failures++;
                $display("FAIL stop_start_idle%0d: busy=%b valid=%b expected 0/0",
                         c, busy, bit_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midrun();
        logic [5:0] outs;
        logic       saw_tick = 1'b0;
        logic       lost_busy = 1'b0;
        do_cfg(16'hA5A5, 5'd16, 28'd2);
        next_cycle();
        start_run(1'b1);
        for (int c = 2; c <= 11; c++) next_cycle();
        @(negedge clk);
        checks++;
        if (led !== 1'b1 || bit_out !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_state: led=%b bit=%b busy=%b expected 1/1/1", led, bit_out, busy);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        outs = {cfg_rej, busy, bit_out, bit_valid, done, led};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL midrun_reset: got %b expected %b", outs, 6'b0);
        end
        // Restored divider is 2**25-1, so no tick may appear in this window.
        next_cycle();
        start_run(1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bit_valid) saw_tick = 1'b1;
            if (!busy) lost_busy = 1'b1;
            next_cycle();
        end
        checks++;
        if (saw_tick !== 1'b0 || lost_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_div: early tick=%b lost busy=%b expected 0/0", saw_tick, lost_busy);
        end
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
    endtask

`ifdef SEQ_PAUSE_EN
    task automatic test_pause();
        logic [4:0] exp_bits = 5'b10110;
        logic       exp_v;
        int         n = 0;
        do_cfg(16'h0016, 5'd5, 28'd3);
        next_cycle();
        start_run(1'b0);
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) next_cycle();
            pause = (c >= 7) && (c <= 16);
            @(negedge clk);
            exp_v = (c == 5) || (c == 19) || (c == 23) || (c == 27) || (c == 31);
            checks++;
            if (bit_valid !== exp_v || (exp_v && bit_out !== exp_bits[4-n]) ||
                done !== (c == 32) || busy !== (c < 32)) begin
                failures++;
                $display("FAIL pause_c%0d: valid=%b bit=%b done=%b busy=%b expected valid %b",
                         c, bit_valid, bit_out, done, busy, exp_v);
            end
            if (exp_v) n++;
        end
        pause = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        mode_loop   = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_div     = '0;
`ifdef SEQ_PAUSE_EN
        pause       = 1'b0;
`endif
        test_reset();
        test_oneshot_default();
        test_loop();
        test_cfg_reject();
        test_stop();
        test_reset_midrun();
`ifdef SEQ_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
